// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encoding,
// default operand width and the board switch field positions.
package div_pkg;

  localparam int unsigned DIV_N = 8;

  // Operand fields on the 16-bit switch bank
  localparam int unsigned SW_DIVISOR_LSB  = 8;
  localparam int unsigned SW_DIVIDEND_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ITER    = 3'd2,
    ST_CORRECT = 3'd3,
    ST_SIGN    = 3'd4,
    ST_DONE    = 3'd5
  } div_state_t;

endpackage

// File: rtl/div_ctrl.sv
// Divider sequencer: FSM plus iteration counter. Produces one-hot phase
// strobes for the datapath and the busy/done handshake outputs.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_eqz,
  input  logic                     i_dz_detect,
  output logic                     o_capture,
  output logic                     o_load,
  output logic                     o_iter,
  output logic                     o_correct,
  output logic                     o_sign,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(N+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(N + 1);

  div_state_t    r_state;
  logic [CW-1:0] r_count;

  // State transitions and iteration count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_count <= CW'(N);
          r_state <= i_dz_detect ? ST_DONE : ST_ITER;
        end
        ST_ITER: begin
          r_count <= r_count - CW'(1);
          if (i_eqz) r_state <= ST_CORRECT;
        end
        ST_CORRECT: r_state <= ST_SIGN;
        ST_SIGN:    r_state <= ST_DONE;
        ST_DONE:    r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Phase strobes decoded from the current state
  always_comb begin
    o_capture = (r_state == ST_IDLE) && i_start;
    o_load    = (r_state == ST_LOAD);
    o_iter    = (r_state == ST_ITER);
    o_correct = (r_state == ST_CORRECT);
    o_sign    = (r_state == ST_SIGN);
    o_done    = (r_state == ST_DONE);
    o_busy    = o_load || o_iter || o_correct || o_sign;
  end

  assign o_count = r_count;

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential N-bit non-restoring divider with start/busy/done handshake.
// Operands come from the switch bank (divisor high field, dividend low
// field); N must not exceed the 8-bit switch fields.
// Build option DIV_SIGNED_EN: signed two's-complement operands with
// truncating division; otherwise operands are unsigned.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  switches,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  localparam int unsigned CW = $clog2(N + 1);

  logic          w_capture;
  logic          w_load;
  logic          w_iter;
  logic          w_correct;
  logic          w_sign;
  logic          w_eqz;
  logic          w_dz_detect;
  logic [CW-1:0] w_count;

  logic [N-1:0]  r_x;
  logic [N-1:0]  r_d;
  logic [N:0]    r_a;
  logic [N-1:0]  r_q;
  logic [N:0]    r_m;
  logic          r_dz;
  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_rem;

  logic [N-1:0]  w_x_mag;
  logic [N-1:0]  w_d_mag;
  logic [N:0]    w_a_shift;
  logic [N:0]    w_a_next;
  logic [N-1:0]  w_rem_mag;
  logic [N-1:0]  w_q_res;
  logic [N-1:0]  w_r_res;

`ifdef DIV_SIGNED_EN
  logic          r_sx;
  logic          r_sq;
`endif

  div_ctrl #(.N(N)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_eqz       (w_eqz),
    .i_dz_detect (w_dz_detect),
    .o_capture   (w_capture),
    .o_load      (w_load),
    .o_iter      (w_iter),
    .o_correct   (w_correct),
    .o_sign      (w_sign),
    .o_busy      (busy),
    .o_done      (done),
    .o_count     (w_count)
  );

  assign w_dz_detect = (r_d == '0);
  assign w_eqz       = ((w_count - CW'(1)) == '0);
  assign w_rem_mag   = r_a[N-1:0];

  // Operand magnitudes and sign fix-up of the final results
  always_comb begin
`ifdef DIV_SIGNED_EN
    w_x_mag = r_x[N-1] ? -r_x : r_x;
    w_d_mag = r_d[N-1] ? -r_d : r_d;
    w_q_res = r_sq ? -r_q : r_q;
    w_r_res = r_sx ? -w_rem_mag : w_rem_mag;
`else
    w_x_mag = r_x;
    w_d_mag = r_d;
    w_q_res = r_q;
    w_r_res = w_rem_mag;
`endif
  end

  // One non-restoring step: shift {A,Q} left, then add or subtract M by sign of A
  always_comb begin
    w_a_shift = {r_a[N-1:0], r_q[N-1]};
    w_a_next  = r_a[N] ? (w_a_shift + r_m) : (w_a_shift - r_m);
  end

  // Datapath registers: operand capture, iteration, correction, result write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_d    <= '0;
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_dz   <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
`ifdef DIV_SIGNED_EN
      r_sx   <= 1'b0;
      r_sq   <= 1'b0;
`endif
    end else begin
      if (w_capture) begin
        r_x  <= switches[SW_DIVIDEND_LSB +: N];
        r_d  <= switches[SW_DIVISOR_LSB +: N];
        r_dz <= 1'b0;
      end
      if (w_load) begin
        if (w_dz_detect) begin
          r_quot <= '1;
          r_rem  <= r_x;
          r_dz   <= 1'b1;
        end else begin
          r_q <= w_x_mag;
          r_m <= {1'b0, w_d_mag};
          r_a <= '0;
`ifdef DIV_SIGNED_EN
          r_sx <= r_x[N-1];
          r_sq <= r_x[N-1] ^ r_d[N-1];
`endif
        end
      end
      if (w_iter) begin
        r_a <= w_a_next;
        r_q <= {r_q[N-2:0], ~w_a_next[N]};
      end
      if (w_correct && r_a[N]) begin
        r_a <= r_a + r_m;
      end
      if (w_sign) begin
        r_quot <= w_q_res;
        r_rem  <= w_r_res;
      end
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign dz        = r_dz;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider (N=8). Expected values follow the
// DIV_SIGNED_EN build option.
module tb_nonrestoring_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] switches;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        dz;

  int n_cmp = 0;
  int n_bad = 0;

  nonrestoring_divider #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .switches  (switches),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, D==0 gives all-ones quotient and X
  function automatic logic [15:0] ref_div(input logic [7:0] x, input logic [7:0] d);
    int xi, di, q, r;
    if (d == 8'h00) return {8'hFF, x};
`ifdef DIV_SIGNED_EN
    xi = int'($signed(x));
    di = int'($signed(d));
`else
    xi = int'(x);
    di = int'(d);
`endif
    q = xi / di;
    r = xi % di;
    return {q[7:0], r[7:0]};
  endfunction

  // Count negedges until done is seen, bounded
  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic run_div(input logic [7:0] x, input logic [7:0] d,
                         output int lat, output logic b1, output logic dz1);
    @(negedge clk);
    switches = {d, x};
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    b1  = busy;
    dz1 = dz;
    wait_done(1, lat);
  endtask

  task automatic check_div(input string tag, input logic [7:0] x, input logic [7:0] d,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input int elat);
    int   lat;
    logic b1, dz1;
    run_div(x, d, lat, b1, dz1);
    chk({tag, "_busy_c1"}, 32'(b1), 32'(1));
    chk({tag, "_dz_c1"}, 32'(dz1), 32'(0));
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_done"}, 32'(busy), 32'(0));
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dz"}, 32'(dz), 32'(edz));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
  endtask

  logic [7:0] vx[24];
  logic [7:0] vd[24];

  initial begin
    int          lat;
    logic [15:0] exp;

    rst      = 1'b1;
    start    = 1'b0;
    switches = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q", 32'(quotient), 32'(0));
    chk("rst_r", 32'(remainder), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_dz", 32'(dz), 32'(0));

    check_div("p100_p7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 12);
`ifdef DIV_SIGNED_EN
    check_div("m100_p7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 12);
    check_div("p100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 12);
`else
    check_div("m100_p7", 8'h9C, 8'd7, 8'h16, 8'h02, 1'b0, 12);
    check_div("p100_m7", 8'd100, 8'hF9, 8'h00, 8'h64, 1'b0, 12);
`endif
    check_div("div0", 8'd55, 8'd0, 8'hFF, 8'h37, 1'b1, 2);
`ifdef DIV_SIGNED_EN
    check_div("x200_3", 8'd200, 8'd3, 8'hEE, 8'hFE, 1'b0, 12);
    check_div("m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 12);
`else
    check_div("x200_3", 8'd200, 8'd3, 8'h42, 8'h02, 1'b0, 12);
    check_div("m128_m1", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 12);
`endif

    // start pulse and switch change while busy must not disturb the operation
    @(negedge clk);
    switches = {8'd7, 8'd100};
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start    = 1'b1;
    switches = 16'h0305;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat);
    chk("midop_lat", 32'(lat), 32'(12));
    chk("midop_q", 32'(quotient), 32'(8'h0E));
    chk("midop_r", 32'(remainder), 32'(8'h02));
    @(negedge clk);
    @(negedge clk);
    chk("midop_no_restart", 32'(busy), 32'(0));

    // reset at cycle 5 aborts and clears outputs immediately
    switches = {8'd3, 8'd200};
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_q", 32'(quotient), 32'(0));
    chk("arst_r", 32'(remainder), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_dz", 32'(dz), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_idle_busy", 32'(busy), 32'(0));
    chk("arst_idle_done", 32'(done), 32'(0));

    // back-to-back sweep with start held high
    vx[0] = 8'h80; vd[0] = 8'hFF;
    vx[1] = 8'h7F; vd[1] = 8'h80;
    vx[2] = 8'h00; vd[2] = 8'h01;
    vx[3] = 8'hFF; vd[3] = 8'h01;
    for (int i = 4; i < 24; i++) begin
      vx[i] = 8'($urandom_range(0, 255));
      vd[i] = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    switches = {vd[0], vx[0]};
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 24; k++) begin
      wait_done(0, lat);
      exp = ref_div(vx[k], vd[k]);
      chk($sformatf("sw%0d_space", k), 32'(lat), 32'((k == 0) ? 12 : 13));
      chk($sformatf("sw%0d_q_%02h_%02h", k, vx[k], vd[k]), 32'(quotient), 32'(exp[15:8]));
      chk($sformatf("sw%0d_r_%02h_%02h", k, vx[k], vd[k]), 32'(remainder), 32'(exp[7:0]));
      chk($sformatf("sw%0d_dz", k), 32'(dz), 32'(0));
      if (k < 23) switches = {vd[k+1], vx[k+1]};
      else        start = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("sweep_end_idle", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
